robertson_mult_n: RTL
=====================

# robertson_mult_n

Parametrised sequential shift-add multiplier: Robertson signed algorithm, plus an unsigned mode selected per operation. Operands are loaded serially over one shared input bus. The block produces a 2·WIDTH-bit product and returns it as two bus words, high half first. It is the WIDTH-generic successor of the fixed 8-bit Robertson datapath in the multiplication_devices library, and adds a start/busy/done handshake and a registered, non-tristated output bus.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..64.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  begins an operation when the block is in IDLE; ignored otherwise.
- is_signed  in  1  sampled together with start. 1 selects two's-complement operands, 0 selects unsigned.
- inbus  in  WIDTH  operand bus: multiplicand M in the start cycle, multiplier Q in the following cycle.
- busy  out  1  high from the cycle after start is accepted until the cycle done is high, inclusive.
- done  out  1  one-cycle pulse, coincident with the low product word.
- out_valid  out  1  outbus carries a product word.
- out_hi  out  1  1 means outbus holds product[2W-1:W]; 0 means product[W-1:0].
- outbus  out  WIDTH  product word; all zeros whenever out_valid is 0.
- fits  out  1  present only with ROBERTSON_FITS_FLAG_EN; see Configuration.

## Operation
- States: IDLE → LOAD_Q → ITER (WIDTH cycles) → OUT_HI → OUT_LO → IDLE.
- IDLE with start=1:
  - Capture M ← inbus and the mode ← is_signed.
  - Clear A (WIDTH bits), F (1 bit) and the iteration counter.
  - Go to LOAD_Q.
- LOAD_Q: capture Q ← inbus, go to ITER.
- ITER, step k = 0..WIDTH-1:
  - Signed mode, k < WIDTH-1: if Q[0]=1 then A ← A + M, and F ← F | M[W-1].
  - Signed mode, k = WIDTH-1: if Q[0]=1 then A ← A − M. F is unchanged.
  - Unsigned mode, every step: if Q[0]=1 then {F,A} ← A + M (F takes the carry). Otherwise F ← 0.
  - Then shift right: {A,Q} ← {F_next, A, Q[W-1:1]}.
  - Leave ITER after the WIDTH-th step.
- Arithmetic requirement: at the end of ITER, {A,Q} equals M×Q exactly as a 2W-bit value. That is signed×signed in signed mode and unsigned×unsigned in unsigned mode. No overflow is possible.
- OUT_HI: out_valid=1, out_hi=1, outbus=A.
- OUT_LO: out_valid=1, out_hi=0, outbus=Q, done=1. Next state is IDLE.
- start while busy is ignored; inbus is don't-care outside the two capture cycles.
- Back-to-back: start may be asserted in the cycle after done and is accepted.

## Timing
- Reset (asynchronous, any state): state=IDLE. M, Q, A, F, counter, mode all zero. Outputs: busy=0, done=0, out_valid=0, out_hi=0, outbus=0, fits=0.
- Reset mid-operation aborts it: no done, no output words. The first clock after deassertion is in IDLE.
- Let start be accepted at edge 0:
  - Q is captured at edge 1.
  - Iterations run on edges 2..WIDTH+1.
  - The high word is valid in the cycle after edge WIDTH+2.
  - The low word and done follow one cycle later.
  - Total: WIDTH+4 cycles from start to done.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro ROBERTSON_FITS_FLAG_EN.
- Defined:
  - Adds output fits, valid together with out_valid and zero otherwise.
  - Signed mode: fits=1 when every bit of A equals Q[W-1], i.e. the product is representable in WIDTH signed bits.
  - Unsigned mode: fits=1 when A==0.
- Not defined: the port does not exist and no comparison logic is generated. All other behaviour is identical.

## Test plan
All cases use WIDTH=8.
- Signed −3 × 5 (inbus 0xFD then 0x05) → words 0xFF, 0xF1. done in cycle 12 after start. fits=1.
- Signed −128 × −128 (0x80, 0x80) → 0x40, 0x00; fits=0. Signed 127 × −1 (0x7F, 0xFF) → 0xFF, 0x81; fits=1.
- Unsigned 255 × 255 (is_signed=0) → 0xFE, 0x01; fits=0. Unsigned 0 × 200 → 0x00, 0x00; fits=1.
- Pulse start in ITER with different inbus data → ignored; the original product is emitted unchanged. A second start in the cycle after done is accepted.
- Assert rst in ITER step 3 → all outputs zero immediately, no done. Then a new signed 6 × 7 operation → 0x00, 0x2A.
- Randomised sweep, both modes, 10k operations → both words match the reference product. outbus=0 whenever out_valid=0.

Source files
------------

// File: rtl/robertson_mult_n_if.sv
// robertson_mult_n_if: start/operand/product bus of the Robertson multiplier; fits exists only with ROBERTSON_FITS_FLAG_EN.
interface robertson_mult_n_if #(parameter int WIDTH = 8);
  logic start, is_signed, busy, done, out_valid, out_hi;
  logic [WIDTH-1:0] inbus, outbus;
`ifdef ROBERTSON_FITS_FLAG_EN
  logic fits;
  modport master (output start, is_signed, inbus, input busy, done, out_valid, out_hi, outbus, fits);
  modport slave (input start, is_signed, inbus, output busy, done, out_valid, out_hi, outbus, fits);
`else
  modport master (output start, is_signed, inbus, input busy, done, out_valid, out_hi, outbus);
  modport slave (input start, is_signed, inbus, output busy, done, out_valid, out_hi, outbus);
`endif
endinterface

// File: rtl/robertson_mult_n.sv
// robertson_mult_n: serial-load shift-add multiplier, signed (Robertson) or unsigned per operation.
// ROBERTSON_FITS_FLAG_EN adds the registered fits flag.
module robertson_mult_n #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  robertson_mult_n_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] IDLE = 3'd0, LOAD_Q = 3'd1, ITER = 3'd2, OUT_HI = 3'd3, OUT_LO = 3'd4;
  logic [2:0] state;
  logic [WIDTH-1:0] m, q, a;
  logic f, sgn, last, accept;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] ax, mx, sum;
  // {F,A} is the partial product widened by one bit: sign in signed mode, carry in unsigned mode
  always_comb begin
    ax = {sgn & f, a};
    mx = {sgn & m[WIDTH-1], m};
    last = cnt == CW'(WIDTH - 1);
    sum = !q[0] ? ax : (sgn && last) ? ax - mx : ax + mx;
    accept = state == IDLE && bus.start && !bus.busy;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      m <= '0;
      q <= '0;
      a <= '0;
      f <= 1'b0;
      sgn <= 1'b0;
      cnt <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_hi <= 1'b0;
      bus.outbus <= '0;
    end else begin
      bus.busy <= accept | (bus.busy & ~bus.done);
      bus.done <= state == OUT_LO;
      bus.out_valid <= state == OUT_HI || state == OUT_LO;
      bus.out_hi <= state == OUT_HI;
      bus.outbus <= state == OUT_HI ? a : state == OUT_LO ? q : '0;
      case (state)
        IDLE: if (accept) begin
          m <= bus.inbus;
          sgn <= bus.is_signed;
          a <= '0;
          f <= 1'b0;
          cnt <= '0;
          state <= LOAD_Q;
        end
        LOAD_Q: begin
          q <= bus.inbus;
          state <= ITER;
        end
        ITER: begin
          {a, q} <= {sum, q[WIDTH-1:1]};
          f <= sum[WIDTH];
          cnt <= cnt + CW'(1);
          state <= last ? OUT_HI : ITER;
        end
        OUT_HI: state <= OUT_LO;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ROBERTSON_FITS_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.fits <= 1'b0;
    else bus.fits <= (state == OUT_HI || state == OUT_LO) && (sgn ? a == {WIDTH{q[WIDTH-1]}} : a == '0);
  end
`endif
endmodule
